// File: rtl/egg_timer_pkg.sv
// Shared encodings and digit limits for the egg timer cook-time front end.
package egg_timer_pkg;

    typedef enum logic [2:0] {
        ST_EDIT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] DIG_S  = 2'd0;
    localparam logic [1:0] DIG_TS = 2'd1;
    localparam logic [1:0] DIG_M  = 2'd2;
    localparam logic [1:0] DIG_TM = 2'd3;

    localparam logic [3:0] MAX_S  = 4'd9;
    localparam logic [3:0] MAX_TS = 4'd5;
    localparam logic [3:0] MAX_M  = 4'd9;
    localparam logic [3:0] MAX_TM = 4'd9;

    function automatic logic [3:0] dig_max(input logic [1:0] idx);
        case (idx)
            DIG_S:   dig_max = MAX_S;
            DIG_TS:  dig_max = MAX_TS;
            DIG_M:   dig_max = MAX_M;
            default: dig_max = MAX_TM;
        endcase
    endfunction

endpackage

// File: rtl/cook_time_entry_if.sv
// Operator-side bundle of cook_time_entry: raw buttons and timer status in,
// programmed digits and time_count controls out.
interface cook_time_entry_if;
    logic       btn_sel;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_start;
    logic       btn_clear;
    logic       timer_zero;
    logic [3:0] seconds_prog;
    logic [3:0] tens_seconds_prog;
    logic [3:0] minutes_prog;
    logic [3:0] tens_minutes_prog;
    logic       load;
    logic       timer_on;
    logic [1:0] digit_sel;
    logic       alarm;

    modport master (
        output btn_sel, btn_inc, btn_dec, btn_start, btn_clear, timer_zero,
        input  seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
        input  load, timer_on, digit_sel, alarm
    );

    modport slave (
        input  btn_sel, btn_inc, btn_dec, btn_start, btn_clear, timer_zero,
        output seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
        output load, timer_on, digit_sel, alarm
    );
endinterface

// File: rtl/button_edge.sv
// Two-flop synchronizer for a raw push-button plus a rising-edge pulse.
// level_o is the synchronized level, used for hold detection.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o,
    output logic level_o
);
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;
    assign level_o = sync2_q;
endmodule

// File: rtl/cook_time_entry.sv
// Cook-time entry FSM: button handling, MM:SS digit editing and run/pause/done
// sequencing for time_count. Define AUTO_REPEAT_EN for held inc/dec auto-repeat.
module cook_time_entry
    import egg_timer_pkg::*;
`ifdef AUTO_REPEAT_EN
#(
    parameter int REPEAT_DELAY = 5,
    parameter int REPEAT_RATE  = 2
)
`endif
(
    input logic              clk,
    input logic              reset,
    cook_time_entry_if.slave bus
);
    // Button index: 0 sel, 1 inc, 2 dec, 3 start, 4 clear
    logic [4:0] pulse, lvl;
    logic [1:0] rpt;
    logic       unused_lvl;

    button_edge u_btn [4:0] (
        .clk     (clk),
        .reset   (reset),
        .btn_i   ({bus.btn_clear, bus.btn_start, bus.btn_dec, bus.btn_inc, bus.btn_sel}),
        .pulse_o (pulse),
        .level_o (lvl)
    );

    state_e          state_q, state_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [1:0]      sel_q, sel_d;
    logic            first_q, first_d;
    logic            load_q, timer_on_q, alarm_q;

`ifdef AUTO_REPEAT_EN
    logic [1:0][7:0] rpt_cnt_q, rpt_cnt_d;

    // Down-counter per inc/dec: delay after the press edge, then fixed rate while held.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt       = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (!lvl[i+1]) begin
                rpt_cnt_d[i] = 8'd0;
            end else if (pulse[i+1]) begin
                rpt_cnt_d[i] = 8'(REPEAT_DELAY - 1);
            end else if (rpt_cnt_q[i] != 8'd0) begin
                rpt_cnt_d[i] = rpt_cnt_q[i] - 8'd1;
            end else begin
                rpt[i]       = (state_q == ST_EDIT);
                rpt_cnt_d[i] = 8'(REPEAT_RATE - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) rpt_cnt_q <= '0;
        else        rpt_cnt_q <= rpt_cnt_d;
    end

    assign unused_lvl = ^{lvl[4:3], lvl[0]};
`else
    assign rpt        = 2'b00;
    assign unused_lvl = ^lvl;
`endif

    logic       inc_step, dec_step, all_zero;
    logic [3:0] cur, mx;

    assign inc_step = pulse[1] | rpt[0];
    assign dec_step = pulse[2] | rpt[1];
    assign all_zero = (dig_q == '0);
    assign cur      = dig_q[sel_q];
    assign mx       = dig_max(sel_q);

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        sel_d   = sel_q;
        first_d = 1'b0;
        case (state_q)
            ST_EDIT: begin
                if (pulse[4]) begin
                    dig_d = '0;
                    sel_d = DIG_S;
                end else if (pulse[3]) begin
                    if (!all_zero) state_d = ST_LOAD;
                end else if (pulse[0]) begin
                    sel_d = sel_q + 2'd1;
                end else if (inc_step && !dec_step) begin
                    dig_d[sel_q] = (cur >= mx) ? 4'd0 : cur + 4'd1;
                end else if (dec_step && !inc_step) begin
                    dig_d[sel_q] = (cur == 4'd0) ? mx : cur - 4'd1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                first_d = 1'b1;
            end
            ST_RUN: begin
                // time_count's zero flag is stale on the cycle right after a reload
                if (pulse[4])                                  state_d = ST_EDIT;
                else if (pulse[3])                             state_d = ST_PAUSE;
                else if (bus.timer_zero && timer_on_q && !first_q) state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (pulse[4])      state_d = ST_EDIT;
                else if (pulse[3]) state_d = ST_RUN;
            end
            ST_DONE: begin
                if (pulse != 5'b0) state_d = ST_EDIT;
            end
            default: state_d = ST_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EDIT;
            dig_q      <= '0;
            sel_q      <= DIG_S;
            first_q    <= 1'b0;
            load_q     <= 1'b0;
            timer_on_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dig_q      <= dig_d;
            sel_q      <= sel_d;
            first_q    <= first_d;
            load_q     <= (state_d == ST_LOAD);
            timer_on_q <= (state_d == ST_RUN);
            alarm_q    <= (state_d == ST_DONE);
        end
    end

    assign bus.seconds_prog      = dig_q[DIG_S];
    assign bus.tens_seconds_prog = dig_q[DIG_TS];
    assign bus.minutes_prog      = dig_q[DIG_M];
    assign bus.tens_minutes_prog = dig_q[DIG_TM];
    assign bus.digit_sel         = sel_q;
    assign bus.load              = load_q;
    assign bus.timer_on          = timer_on_q;
    assign bus.alarm             = alarm_q;
endmodule

// File: tb/tb_cook_time_entry.sv
// Self-checking bench for cook_time_entry with a digit-level model of the operator rules.
module tb_cook_time_entry;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cook_time_entry_if bus();
    cook_time_entry dut (.clk(clk), .reset(reset), .bus(bus.slave));

    localparam logic [4:0] B_SEL = 5'b00001, B_INC = 5'b00010, B_DEC = 5'b00100,
                           B_START = 5'b01000, B_CLR = 5'b10000;

    int checks = 0, errors = 0;
    int m_dig[4];
    int m_sel;
    int load_pulses = 0;

    always @(negedge clk) if (bus.load === 1'b1) load_pulses++;

    function automatic int mx(input int i);
        return (i == 1) ? 5 : 9;
    endfunction

    function automatic logic [17:0] exp_vec();
        return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0]), 2'(m_sel)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {bus.tens_minutes_prog, bus.minutes_prog, bus.tens_seconds_prog,
                bus.seconds_prog, bus.digit_sel};
    endfunction

    // Editing rules of the operator front end, applied to the model
    task automatic model_edit(input logic [4:0] m);
        if (m[4]) begin
            foreach (m_dig[i]) m_dig[i] = 0;
            m_sel = 0;
        end else if (m[3]) begin
        end else if (m[0]) m_sel = (m_sel + 1) % 4;
        else if (m[1] && !m[2]) m_dig[m_sel] = (m_dig[m_sel] + 1) % (mx(m_sel) + 1);
        else if (m[2] && !m[1]) m_dig[m_sel] = (m_dig[m_sel] + mx(m_sel)) % (mx(m_sel) + 1);
    endtask

    task automatic press(input logic [4:0] m, input int hold);
        @(negedge clk);
        {bus.btn_clear, bus.btn_start, bus.btn_dec, bus.btn_inc, bus.btn_sel} = m;
        repeat (hold) @(negedge clk);
        {bus.btn_clear, bus.btn_start, bus.btn_dec, bus.btn_inc, bus.btn_sel} = 5'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic program_digits(input int s, input int ts, input int mm, input int tm);
        int v[4];
        v = '{s, ts, mm, tm};
        press(B_CLR, 1); model_edit(B_CLR);
        for (int i = 0; i < 4; i++) begin
            repeat (v[i]) begin press(B_INC, 1); model_edit(B_INC); end
            press(B_SEL, 1); model_edit(B_SEL);
        end
    endtask

    task automatic test_reset();
        {bus.btn_clear, bus.btn_start, bus.btn_dec, bus.btn_inc, bus.btn_sel} = 5'b0;
        bus.timer_zero = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        foreach (m_dig[i]) m_dig[i] = 0;
        m_sel = 0;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_digits: got %h want %h", dut_vec(), exp_vec());
        end
        checks++;
        if ({bus.load, bus.timer_on, bus.alarm} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.load, bus.timer_on, bus.alarm});
        end
    endtask

    task automatic test_edit_random();
        logic [4:0] m;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       m = B_SEL;
                1, 2:    m = B_INC;
                3:       m = B_DEC;
                default: m = B_INC | B_DEC;
            endcase
            press(m, $urandom_range(1, 3));
            model_edit(m);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL edit_random[%0d] op %b: got %h want %h", n, m, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ts_wrap();
        press(B_CLR, 1); model_edit(B_CLR);
        press(B_SEL, 1); model_edit(B_SEL);
        repeat (7) begin press(B_INC, 1); model_edit(B_INC); end
        checks++;
        if (bus.tens_seconds_prog !== 4'd1 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL ts_wrap: got %h want %h", dut_vec(), exp_vec());
        end
        press(B_INC | B_DEC, 2);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL inc_dec_same: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_start_zero();
        int base;
        press(B_CLR, 1); model_edit(B_CLR);
        base = load_pulses;
        press(B_START, 2);
        checks++;
        if (load_pulses != base || bus.timer_on !== 1'b0) begin
            errors++; $display("FAIL start_zero: got loads %0d timer_on %b want 0 0", load_pulses - base, bus.timer_on);
        end
        press(B_INC, 1); model_edit(B_INC);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL start_zero_edit: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_load_run();
        int base, first_at;
        program_digits(4, 3, 2, 1);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL program_1234: got %h want %h", dut_vec(), exp_vec());
        end
        base = load_pulses;
        first_at = -1;
        @(negedge clk);
        bus.btn_start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.btn_start = 1'b0;
            if (bus.load === 1'b1 && first_at < 0) first_at = c;
        end
        checks++;
        if (load_pulses - base != 1 || first_at != 2) begin
            errors++; $display("FAIL load_pulse: got count %0d at %0d want 1 at 2", load_pulses - base, first_at);
        end
        checks++;
        if (bus.timer_on !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL run_on: got on %b dig %h want 1 %h", bus.timer_on, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_pause_and_run_controls();
        int base;
        base = load_pulses;
        press(B_START, 1);
        checks++;
        if (bus.timer_on !== 1'b0) begin
            errors++; $display("FAIL pause_off: got %b want 0", bus.timer_on);
        end
        press(B_START, 1);
        checks++;
        if (bus.timer_on !== 1'b1 || load_pulses != base) begin
            errors++; $display("FAIL resume: got on %b loads %0d want 1 0", bus.timer_on, load_pulses - base);
        end
        press(B_INC, 1); press(B_SEL, 1); press(B_DEC, 1);
        checks++;
        if (dut_vec() !== exp_vec() || bus.timer_on !== 1'b1) begin
            errors++; $display("FAIL run_frozen: got %h on %b want %h 1", dut_vec(), bus.timer_on, exp_vec());
        end
        press(B_CLR, 1);
        checks++;
        if (dut_vec() !== exp_vec() || bus.timer_on !== 1'b0) begin
            errors++; $display("FAIL run_abort: got %h on %b want %h 0", dut_vec(), bus.timer_on, exp_vec());
        end
        press(B_SEL, 1); model_edit(B_SEL);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL abort_edit: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_alarm();
        int on_cnt;
        logic got;
        program_digits(3, 0, 0, 0);
        bus.timer_zero = 1'b1;
        on_cnt = 0;
        got = 1'b0;
        @(negedge clk);
        bus.btn_start = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) bus.btn_start = 1'b0;
            if (bus.alarm === 1'b1) got = 1'b1;
            else if (bus.timer_on === 1'b1) on_cnt++;
        end
        bus.btn_start = 1'b0;
        checks++;
        if (!got || on_cnt != 2) begin
            errors++; $display("FAIL alarm_entry: got seen %b run_cycles %0d want 1 2", got, on_cnt);
        end
        checks++;
        if (bus.timer_on !== 1'b0) begin
            errors++; $display("FAIL alarm_timer_off: got %b want 0", bus.timer_on);
        end
        bus.timer_zero = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.alarm !== 1'b1) begin
            errors++; $display("FAIL alarm_hold: got %b want 1", bus.alarm);
        end
        press(B_CLR, 1);
        checks++;
        if (bus.alarm !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL done_clear: got alarm %b dig %h want 0 %h", bus.alarm, dut_vec(), exp_vec());
        end
        press(B_INC, 1); model_edit(B_INC);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL done_to_edit: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_run();
        press(B_START, 1);
        checks++;
        if (bus.timer_on !== 1'b1) begin
            errors++; $display("FAIL pre_reset_run: got %b want 1", bus.timer_on);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (m_dig[i]) m_dig[i] = 0;
        m_sel = 0;
        @(negedge clk);
        checks++;
        if (dut_vec() !== exp_vec() || {bus.load, bus.timer_on, bus.alarm} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_run: got %h ctrl %b want %h 000", dut_vec(),
                               {bus.load, bus.timer_on, bus.alarm}, exp_vec());
        end
        press(B_INC, 1); model_edit(B_INC);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_to_edit: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int hold, steps;
        press(B_CLR, 1); model_edit(B_CLR);
        hold = 11;
        // one step on the edge, then one at 5 cycles and every 2 cycles after while held
        steps = 1;
        for (int t = 5; t <= hold - 1; t += 2) steps++;
        press(B_INC, hold);
        repeat (steps) model_edit(B_INC);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL auto_repeat: got %h want %h", dut_vec(), exp_vec());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_edit_random();
        test_ts_wrap();
        test_start_zero();
        test_load_run();
        test_pause_and_run_controls();
        test_alarm();
        test_reset_mid_run();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
